// File: rtl/gamepad_pmod_rx.sv
// rtl/gamepad_pmod_rx.sv - serial gamepad PMOD receiver publishing two 12-bit controller words
module gamepad_pmod_rx #(
  parameter int NUM_BITS       = 24,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pmod_data,
  input  logic        pmod_clk,
  input  logic        pmod_latch,
  output logic [11:0] pad1_buttons,
  output logic [11:0] pad2_buttons,
  output logic        pad1_present,
  output logic        pad2_present,
  output logic        button_up,
  output logic        button_down,
  output logic        frame_valid,
  output logic        frame_error
);

  localparam int         TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [4:0] CNT_FULL = 5'(NUM_BITS);
  localparam logic [4:0] CNT_SAT  = 5'(NUM_BITS + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);

  // data needs no edge history; clk/latch carry {prev, sync2, sync1}
  logic [1:0] data_sync;
  logic [2:0] clk_sync;
  logic [2:0] latch_sync;
  logic       clk_rise;
  logic       latch_rise;

  logic [NUM_BITS-1:0] shift_reg;
  logic [4:0]          bit_cnt;

  logic                cap_ok;
  logic                cap_err;
  logic [NUM_BITS-1:0] cap_data;

  logic [11:0]   raw1;
  logic [11:0]   raw2;
  logic          present1_q;
  logic          present2_q;
  logic [TW-1:0] to_cnt;
  logic          timed_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_sync  <= '0;
      clk_sync   <= '0;
      latch_sync <= '0;
    end else begin
      data_sync  <= {data_sync[0], pmod_data};
      clk_sync   <= {clk_sync[1:0], pmod_clk};
      latch_sync <= {latch_sync[1:0], pmod_latch};
    end
  end

  assign clk_rise   = clk_sync[1] & ~clk_sync[2];
  assign latch_rise = latch_sync[1] & ~latch_sync[2];

  // A clock edge coinciding with a latch is the first bit of the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else begin
      if (clk_rise) begin
        shift_reg <= {shift_reg[NUM_BITS-2:0], data_sync[1]};
      end
      if (latch_rise) begin
        bit_cnt <= clk_rise ? 5'd1 : 5'd0;
      end else if (clk_rise && bit_cnt != CNT_SAT) begin
        bit_cnt <= bit_cnt + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_ok   <= 1'b0;
      cap_err  <= 1'b0;
      cap_data <= '0;
    end else begin
      cap_ok   <= latch_rise && (bit_cnt == CNT_FULL);
      cap_err  <= latch_rise && (bit_cnt != CNT_FULL);
      if (latch_rise) begin
        cap_data <= shift_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw1        <= '0;
      raw2        <= '0;
      present1_q  <= 1'b0;
      present2_q  <= 1'b0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      to_cnt      <= '0;
    end else begin
      frame_valid <= cap_ok;
      frame_error <= cap_err;
      if (cap_ok) begin
        raw1       <= cap_data[23:12];
        raw2       <= cap_data[11:0];
        present1_q <= (cap_data[23:12] != 12'hFFF);
        present2_q <= (cap_data[11:0] != 12'hFFF);
        to_cnt     <= '0;
      end else if (to_cnt != TO_MAX) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  assign timed_out    = (to_cnt == TO_MAX);
  assign pad1_present = present1_q & ~timed_out;
  assign pad2_present = present2_q & ~timed_out;
  assign pad1_buttons = pad1_present ? raw1 : 12'h000;
  assign pad2_buttons = pad2_present ? raw2 : 12'h000;

  // bit 7 = UP, bit 6 = DOWN, bit 3 = A
  assign button_up   = pad1_buttons[7] | pad1_buttons[3];
  assign button_down = pad1_buttons[6];

endmodule

// File: tb/tb_gamepad_pmod_rx.sv
// tb/tb_gamepad_pmod_rx.sv - testbench for gamepad_pmod_rx
module tb_gamepad_pmod_rx;

  logic        clk;
  logic        rst_n;
  logic        pmod_data;
  logic        pmod_clk;
  logic        pmod_latch;
  logic [11:0] pad1_buttons;
  logic [11:0] pad2_buttons;
  logic        pad1_present;
  logic        pad2_present;
  logic        button_up;
  logic        button_down;
  logic        frame_valid;
  logic        frame_error;

  gamepad_pmod_rx #(.NUM_BITS(24), .TIMEOUT_CYCLES(1000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pmod_data    (pmod_data),
    .pmod_clk     (pmod_clk),
    .pmod_latch   (pmod_latch),
    .pad1_buttons (pad1_buttons),
    .pad2_buttons (pad2_buttons),
    .pad1_present (pad1_present),
    .pad2_present (pad2_present),
    .button_up    (button_up),
    .button_down  (button_down),
    .frame_valid  (frame_valid),
    .frame_error  (frame_error)
  );

  typedef struct {
    logic [23:0] word;
    int          nbits;
    bit          err;
    logic [11:0] p1;
    logic [11:0] p2;
    bit          pr1;
    bit          pr2;
    bit          up;
    bit          dn;
    int          exp_cyc;
  } vec_t;

  vec_t tbl[9];
  vec_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_valid_cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t mk(input logic [23:0] w, input int n, input bit e,
                              input logic [11:0] p1, input logic [11:0] p2,
                              input bit pr1, input bit pr2, input bit up, input bit dn);
    vec_t v;
    v.word = w; v.nbits = n; v.err = e; v.p1 = p1; v.p2 = p2;
    v.pr1 = pr1; v.pr2 = pr2; v.up = up; v.dn = dn; v.exp_cyc = 0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic send_bits(input logic [23:0] w, input int first, input int n);
    logic [23:0] wl;
    wl = w;
    for (int i = first; i < first + n; i++) begin
      pmod_data = (i < 24) ? wl[23-i] : 1'b0;
      repeat (4) @(negedge clk);
      pmod_clk = 1'b1;
      repeat (4) @(negedge clk);
      pmod_clk = 1'b0;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic do_latch(input vec_t v, input bit with_clk);
    vec_t e;
    e = v;
    e.exp_cyc = cyc + 4;
    sb_q.push_back(e);
    pmod_latch = 1'b1;
    if (with_clk) pmod_clk = 1'b1;
    repeat (4) @(negedge clk);
    pmod_latch = 1'b0;
    pmod_clk   = 1'b0;
    repeat (5) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    send_bits(v.word, 0, v.nbits);
    do_latch(v, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_p1"}, 32'(pad1_buttons), 32'd0);
    chk({tag, "_p2"}, 32'(pad2_buttons), 32'd0);
    chk({tag, "_pr1"}, 32'(pad1_present), 32'd0);
    chk({tag, "_pr2"}, 32'(pad2_present), 32'd0);
    chk({tag, "_up"}, 32'(button_up), 32'd0);
    chk({tag, "_dn"}, 32'(button_down), 32'd0);
    chk({tag, "_valid"}, 32'(frame_valid), 32'd0);
    chk({tag, "_err"}, 32'(frame_error), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && (frame_valid || frame_error)) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse actual valid=%0b err=%0b expected none (cycle %0d)",
                 frame_valid, frame_error, cyc);
      end else begin
        vec_t e;
        e = sb_q.pop_front();
        chk("latency", 32'(cyc), 32'(e.exp_cyc));
        chk("frame_valid", 32'(frame_valid), 32'(!e.err));
        chk("frame_error", 32'(frame_error), 32'(e.err));
        chk("pad1_buttons", 32'(pad1_buttons), 32'(e.p1));
        chk("pad2_buttons", 32'(pad2_buttons), 32'(e.p2));
        chk("pad1_present", 32'(pad1_present), 32'(e.pr1));
        chk("pad2_present", 32'(pad2_present), 32'(e.pr2));
        chk("button_up", 32'(button_up), 32'(e.up));
        chk("button_down", 32'(button_down), 32'(e.dn));
        if (frame_valid) last_valid_cyc = cyc;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    int   l;
    tbl[0] = mk(24'h800FFF, 24, 0, 12'h800, 12'h000, 1, 0, 0, 0);
    tbl[1] = mk(24'h080000, 24, 0, 12'h080, 12'h000, 1, 1, 1, 0);
    tbl[2] = mk(24'h04000F, 24, 0, 12'h040, 12'h00F, 1, 1, 0, 1);
    tbl[3] = mk(24'h008FFF, 24, 0, 12'h008, 12'h000, 1, 0, 1, 0);
    tbl[4] = mk(24'hABC123, 23, 1, 12'h008, 12'h000, 1, 0, 1, 0);
    tbl[5] = mk(24'hFFF555, 24, 0, 12'h000, 12'h555, 0, 1, 0, 0);
    tbl[6] = mk(24'h000000,  0, 1, 12'h000, 12'h555, 0, 1, 0, 0);
    tbl[7] = mk(24'h123456, 24, 0, 12'h123, 12'h456, 1, 1, 0, 0);
    tbl[8] = mk(24'h0F0F0F, 25, 1, 12'h123, 12'h456, 1, 1, 0, 0);

    rst_n = 1'b0; pmod_data = 1'b0; pmod_clk = 1'b0; pmod_latch = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(tbl[i]);

    // clock and latch rise together: capture pre-shift frame, new frame starts at bit_cnt=1
    send_bits(24'h0C07FF, 0, 24);
    pmod_data = 1'b0;
    repeat (4) @(negedge clk);
    do_latch(mk(24'h0C07FF, 24, 0, 12'h0C0, 12'h7FF, 1, 1, 1, 1), 1'b1);
    send_bits(24'h00FFFF, 1, 23);
    do_latch(mk(24'h00FFFF, 24, 0, 12'h00F, 12'h000, 1, 0, 1, 0), 1'b0);

    // link timeout
    run_vec(mk(24'h0F00F0, 24, 0, 12'h0F0, 12'h0F0, 1, 1, 1, 1));
    l = last_valid_cyc;
    while (cyc < l + 999) @(negedge clk);
    chk("to_before_pr1", 32'(pad1_present), 32'd1);
    chk("to_before_p1", 32'(pad1_buttons), 32'h0F0);
    @(negedge clk);
    chk("to_cycle", 32'(cyc), 32'(l + 1000));
    chk_all_zero("timeout");
    run_vec(mk(24'h321FFE, 24, 0, 12'h321, 12'hFFE, 1, 1, 0, 0));

    // reset in the middle of a frame
    send_bits(24'h555AAA, 0, 10);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    pmod_data = 1'b0;
    repeat (2) @(negedge clk);
    v = mk(24'h0A0FFF, 24, 0, 12'h0A0, 12'h000, 1, 0, 1, 0);
    run_vec(v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
